// File: rtl/alu_request_arbiter_pkg.sv
// Shared definitions for the ALU request arbiter and the ALU function decoder.
package alu_request_arbiter_pkg;

    localparam int unsigned ALU_DATA_W = 32;
    localparam int unsigned ALU_FUNC_W = 6;

    // ALU function codes; bit 5 marks floating-point operations.
    localparam logic [ALU_FUNC_W-1:0] FUNC_ADD  = 6'b000000;
    localparam logic [ALU_FUNC_W-1:0] FUNC_SUB  = 6'b000001;
    localparam logic [ALU_FUNC_W-1:0] FUNC_AND  = 6'b000100;
    localparam logic [ALU_FUNC_W-1:0] FUNC_OR   = 6'b000101;
    localparam logic [ALU_FUNC_W-1:0] FUNC_XOR  = 6'b000110;
    localparam logic [ALU_FUNC_W-1:0] FUNC_SLL  = 6'b001000;
    localparam logic [ALU_FUNC_W-1:0] FUNC_SRL  = 6'b001001;
    localparam logic [ALU_FUNC_W-1:0] FUNC_MUL  = 6'b010000;
    localparam logic [ALU_FUNC_W-1:0] FUNC_DIV  = 6'b010100;
    localparam logic [ALU_FUNC_W-1:0] FUNC_FADD = 6'b100000;
    localparam logic [ALU_FUNC_W-1:0] FUNC_FMUL = 6'b100010;
    localparam logic [ALU_FUNC_W-1:0] FUNC_FDIV = 6'b100100;

    // Arbiter FSM state encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESP   = 3'd4
    } arb_state_e;

    // Operation payload as seen by the ALU.
    typedef struct packed {
        logic [ALU_FUNC_W-1:0] funk;
        logic [ALU_DATA_W-1:0] daten1;
        logic [ALU_DATA_W-1:0] daten2;
    } alu_op_t;

    // True for floating-point function codes.
    function automatic logic is_float_op(input logic [ALU_FUNC_W-1:0] funk);
        return funk[ALU_FUNC_W-1];
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with a single pointer bit.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant_c
);

    logic ptr;

    // Sole requester wins; a contested grant goes to the pointer.
    always_comb begin
        grant_c = 2'b00;
        if (valid == 2'b11) begin
            grant_c = ptr ? 2'b10 : 2'b01;
        end else begin
            grant_c = valid;
        end
    end

    // Pointer moves to the other requester after a contested grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (accept && (valid == 2'b11)) begin
            ptr <= ~ptr;
        end
    end

endmodule

// File: rtl/alu_request_arbiter.sv
// Shares one multi-cycle ALU between the instruction pipeline (0) and the
// auxiliary unit (1); issues one op at a time and recovers a hung ALU.
module alu_request_arbiter
    import alu_request_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W      = ALU_DATA_W,
    parameter int unsigned FUNC_W      = ALU_FUNC_W,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Req0Valid,
    output logic              Req0Ready,
    input  logic [FUNC_W-1:0] Req0Funk,
    input  logic [DATA_W-1:0] Req0Daten1,
    input  logic [DATA_W-1:0] Req0Daten2,
    input  logic              Req1Valid,
    output logic              Req1Ready,
    input  logic [FUNC_W-1:0] Req1Funk,
    input  logic [DATA_W-1:0] Req1Daten1,
    input  logic [DATA_W-1:0] Req1Daten2,
    output logic              Resp0Valid,
    input  logic              Resp0Ready,
    output logic [DATA_W-1:0] Resp0Ergeb,
    output logic              Resp0Fehler,
    output logic              Resp1Valid,
    input  logic              Resp1Ready,
    output logic [DATA_W-1:0] Resp1Ergeb,
    output logic              Resp1Fehler,
    output logic [DATA_W-1:0] AluDaten1,
    output logic [DATA_W-1:0] AluDaten2,
    output logic [FUNC_W-1:0] AluFunk,
    output logic              AluStart,
    output logic              AluReset,
    input  logic              AluFertig,
    input  logic [DATA_W-1:0] AluErgebnis,
    output logic              Busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    arb_state_e        state;
    arb_state_e        state_next;
    logic [1:0]        req_valid;
    logic [1:0]        grant_c;
    logic              accept;
    logic              owner;
    logic              owner_ready;
    logic [CNT_W-1:0]  wait_cnt;
    logic              timeout_hit;
    logic [DATA_W-1:0] result;
    logic              fehler;
    logic              start_d;
    logic              alu_reset_d;
    logic [1:0]        resp_valid_d;
    logic              busy_d;

    assign req_valid   = {Req1Valid, Req0Valid};
    assign accept      = (state == ST_IDLE) && (req_valid != 2'b00);
    assign Req0Ready   = (state == ST_IDLE) && grant_c[0];
    assign Req1Ready   = (state == ST_IDLE) && grant_c[1];
    assign owner_ready = owner ? Resp1Ready : Resp0Ready;
    assign timeout_hit = (state == ST_WAIT) && !AluFertig
                         && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Result port registers are shared; only the owner's Valid is raised.
    assign Resp0Ergeb  = result;
    assign Resp1Ergeb  = result;
    assign Resp0Fehler = fehler;
    assign Resp1Fehler = fehler;

    rr_arbiter2 u_rr_arbiter2 (
        .clk     (Clock),
        .rst     (Reset),
        .valid   (req_valid),
        .accept  (accept),
        .grant_c (grant_c)
    );

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and next values of the registered control outputs.
    always_comb begin
        state_next   = state;
        start_d      = 1'b0;
        alu_reset_d  = 1'b0;
        resp_valid_d = 2'b00;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_ISSUE;
                    start_d    = 1'b1;
                end
            end
            ST_ISSUE:  state_next = ST_SETTLE;
            ST_SETTLE: state_next = ST_WAIT;
            ST_WAIT: begin
                if (AluFertig) begin
                    state_next = ST_RESP;
                end else if (timeout_hit) begin
                    state_next  = ST_RESP;
                    alu_reset_d = 1'b1;
                end
            end
            ST_RESP: begin
                if (owner_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (state_next == ST_RESP) begin
            resp_valid_d = owner ? 2'b10 : 2'b01;
        end
        busy_d = (state_next != ST_IDLE);
    end

    // Registered control outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            AluStart   <= 1'b0;
            AluReset   <= 1'b0;
            Resp0Valid <= 1'b0;
            Resp1Valid <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            AluStart   <= start_d;
            AluReset   <= alu_reset_d;
            Resp0Valid <= resp_valid_d[0];
            Resp1Valid <= resp_valid_d[1];
            Busy       <= busy_d;
        end
    end

    // Operand latch; held from ISSUE until the next accept.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            owner     <= 1'b0;
            AluFunk   <= '0;
            AluDaten1 <= '0;
            AluDaten2 <= '0;
        end else if (accept) begin
            owner <= grant_c[1];
            if (grant_c[1]) begin
                AluFunk   <= Req1Funk;
                AluDaten1 <= Req1Daten1;
                AluDaten2 <= Req1Daten2;
            end else begin
                AluFunk   <= Req0Funk;
                AluDaten1 <= Req0Daten1;
                AluDaten2 <= Req0Daten2;
            end
        end
    end

    // WAIT-cycle counter: cleared in SETTLE, saturating in WAIT.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wait_cnt <= '0;
        end else if (state == ST_SETTLE) begin
            wait_cnt <= '0;
        end else if ((state == ST_WAIT) && (wait_cnt != CNT_W'(TIMEOUT_CYC))) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Result capture on completion or abort; held through RESP.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            result <= '0;
            fehler <= 1'b0;
        end else if ((state == ST_WAIT) && AluFertig) begin
            result <= AluErgebnis;
            fehler <= 1'b0;
        end else if (timeout_hit) begin
            result <= '0;
            fehler <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_request_arbiter.sv
// Self-checking bench for alu_request_arbiter; the bench plays the ALU.
module tb_alu_request_arbiter;
    import alu_request_arbiter_pkg::*;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned FUNC_W      = 6;
    localparam int unsigned TIMEOUT_CYC = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req0_valid = 1'b0, req1_valid = 1'b0;
    logic              req0_ready, req1_ready;
    logic [FUNC_W-1:0] req0_funk = '0, req1_funk = '0;
    logic [DATA_W-1:0] req0_d1 = '0, req0_d2 = '0, req1_d1 = '0, req1_d2 = '0;
    logic              resp0_valid, resp1_valid;
    logic              resp0_ready = 1'b0, resp1_ready = 1'b0;
    logic [DATA_W-1:0] resp0_ergeb, resp1_ergeb;
    logic              resp0_fehler, resp1_fehler;
    logic [DATA_W-1:0] alu_d1, alu_d2;
    logic [FUNC_W-1:0] alu_funk;
    logic              alu_start, alu_reset;
    logic              alu_fertig = 1'b0;
    logic [DATA_W-1:0] alu_ergebnis = '0;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;
    int ptr_m    = 0;   // round-robin preference of the reference model
    int grants[$];      // grant history

    always #5 clk = ~clk;

    alu_request_arbiter #(
        .DATA_W(DATA_W), .FUNC_W(FUNC_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .Clock(clk), .Reset(rst),
        .Req0Valid(req0_valid), .Req0Ready(req0_ready), .Req0Funk(req0_funk),
        .Req0Daten1(req0_d1), .Req0Daten2(req0_d2),
        .Req1Valid(req1_valid), .Req1Ready(req1_ready), .Req1Funk(req1_funk),
        .Req1Daten1(req1_d1), .Req1Daten2(req1_d2),
        .Resp0Valid(resp0_valid), .Resp0Ready(resp0_ready),
        .Resp0Ergeb(resp0_ergeb), .Resp0Fehler(resp0_fehler),
        .Resp1Valid(resp1_valid), .Resp1Ready(resp1_ready),
        .Resp1Ergeb(resp1_ergeb), .Resp1Fehler(resp1_fehler),
        .AluDaten1(alu_d1), .AluDaten2(alu_d2), .AluFunk(alu_funk),
        .AluStart(alu_start), .AluReset(alu_reset),
        .AluFertig(alu_fertig), .AluErgebnis(alu_ergebnis), .Busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stand-in ALU behaviour used to produce result values.
    function automatic logic [31:0] alu_ref(input logic [5:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        case (f)
            FUNC_ADD: return a + b;
            FUNC_SUB: return a - b;
            FUNC_AND: return a & b;
            FUNC_OR:  return a | b;
            FUNC_XOR: return a ^ b;
            default:  return a ^ {b[15:0], b[31:16]} ^ 32'h5a5a_0000;
        endcase
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_start"}, 32'(alu_start), 32'd0);
        check({tag, "_alurst"}, 32'(alu_reset), 32'd0);
        check({tag, "_rv"}, 32'({resp1_valid, resp0_valid}), 32'd0);
        check({tag, "_erg"}, resp0_ergeb | resp1_ergeb, 32'd0);
        check({tag, "_feh"}, 32'({resp1_fehler, resp0_fehler}), 32'd0);
        check({tag, "_ops"}, alu_d1 | alu_d2 | 32'(alu_funk), 32'd0);
        check({tag, "_rdy"}, 32'({req1_ready, req0_ready}), 32'd0);
    endtask

    task automatic set_req(input int id, input logic [5:0] f, input logic [31:0] a,
                           input logic [31:0] b);
        if (id == 0) begin
            req0_valid = 1'b1; req0_funk = f; req0_d1 = a; req0_d2 = b;
        end else begin
            req1_valid = 1'b1; req1_funk = f; req1_d1 = a; req1_d2 = b;
        end
    endtask

    task automatic check_ops(input string tag, input logic [5:0] f, input logic [31:0] a,
                             input logic [31:0] b);
        check({tag, "_funk"}, 32'(alu_funk), 32'(f));
        check({tag, "_d1"}, alu_d1, a);
        check({tag, "_d2"}, alu_d2, b);
    endtask

    // One complete job from a negedge in IDLE with requests already driven.
    // lat = WAIT cycle in which the ALU finishes (0 = never), hold = Resp Ready low cycles.
    task automatic run_job(input int lat, input int hold, input logic stale);
        int g;
        logic [5:0]  ef;
        logic [31:0] ea, eb, er, exp_erg;
        logic        tmo;
        if (req0_valid && req1_valid) begin
            g = ptr_m; ptr_m = 1 - ptr_m;
        end else begin
            g = req1_valid ? 1 : 0;
        end
        grants.push_back(g);
        ef = g ? req1_funk : req0_funk;
        ea = g ? req1_d1 : req0_d1;
        eb = g ? req1_d2 : req0_d2;
        er = alu_ref(ef, ea, eb);
        tmo = (lat == 0);
        exp_erg = tmo ? 32'd0 : er;
        #1;
        check("idle_ready", 32'({req1_ready, req0_ready}), g ? 32'd2 : 32'd1);
        // ISSUE
        @(negedge clk);
        check("issue_start", 32'(alu_start), 32'd1);
        check("issue_busy", 32'(busy), 32'd1);
        check("issue_rdy", 32'({req1_ready, req0_ready}), 32'd0);
        check_ops("issue", ef, ea, eb);
        if (g == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        alu_fertig = stale;
        alu_ergebnis = $urandom;
        // SETTLE
        @(negedge clk);
        check("settle_start", 32'(alu_start), 32'd0);
        check("settle_rv", 32'({resp1_valid, resp0_valid}), 32'd0);
        check_ops("settle", ef, ea, eb);
        alu_fertig = stale;
        // WAIT
        for (int k = 1; k <= int'(TIMEOUT_CYC); k++) begin
            @(negedge clk);
            check("wait_ctl", 32'({alu_start, alu_reset, resp1_valid, resp0_valid}), 32'd0);
            check("wait_rdy", 32'({req1_ready, req0_ready}), 32'd0);
            check_ops("wait", ef, ea, eb);
            if (k == lat) begin
                alu_fertig = 1'b1; alu_ergebnis = er;
                break;
            end
            alu_fertig = 1'b0;
            alu_ergebnis = $urandom;
        end
        // first RESP cycle
        @(negedge clk);
        alu_fertig = 1'b0;
        alu_ergebnis = $urandom;
        check("resp_valid", 32'({resp1_valid, resp0_valid}), g ? 32'd2 : 32'd1);
        check("resp_erg", g ? resp1_ergeb : resp0_ergeb, exp_erg);
        check("resp_feh", 32'(g ? resp1_fehler : resp0_fehler), 32'(tmo));
        check("resp_alurst", 32'(alu_reset), 32'(tmo));
        check("resp_start", 32'(alu_start), 32'd0);
        for (int h = 0; h < hold; h++) begin
            if (g == 0) resp1_ready = 1'b1; else resp0_ready = 1'b1;
            @(negedge clk);
            check("hold_valid", 32'({resp1_valid, resp0_valid}), g ? 32'd2 : 32'd1);
            check("hold_erg", g ? resp1_ergeb : resp0_ergeb, exp_erg);
            check("hold_feh", 32'(g ? resp1_fehler : resp0_fehler), 32'(tmo));
            check("hold_alurst", 32'(alu_reset), 32'd0);
            check("hold_rdy", 32'({req1_ready, req0_ready}), 32'd0);
            resp0_ready = 1'b0; resp1_ready = 1'b0;
        end
        if (g == 0) resp0_ready = 1'b1; else resp1_ready = 1'b1;
        @(negedge clk);
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        check("done_rv", 32'({resp1_valid, resp0_valid}), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [5:0] funcs [6];
        funcs = '{FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_XOR, FUNC_FDIV, FUNC_MUL};

        // Reset
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("rst_on");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("rst_off");

        // Single add, done in the first WAIT cycle
        set_req(0, FUNC_ADD, 32'd5, 32'd7);
        run_job(1, 0, 1'b0);

        // Both requesters valid from reset: 0,1,0,1
        rst = 1'b1; @(negedge clk); rst = 1'b0; ptr_m = 0;
        grants.delete();
        for (int j = 0; j < 4; j++) begin
            set_req(0, FUNC_SUB, 32'd100 + 32'(j), 32'd3);
            set_req(1, FUNC_OR, 32'h0f00 + 32'(j), 32'h00f0);
            run_job(j + 1, j, 1'b0);
        end
        for (int j = 0; j < 4; j++) check("rr_order", 32'(grants[j]), 32'(j % 2));
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Long float divide with stale done during ISSUE/SETTLE
        set_req(1, FUNC_FDIV, 32'h4049_0fdb, 32'h4000_0000);
        run_job(31, 0, 1'b1);

        // Hung ALU -> timeout abort
        set_req(0, FUNC_MUL, 32'd9, 32'd9);
        run_job(0, 0, 1'b0);

        // Response back-pressure with the other requester waiting
        set_req(0, FUNC_XOR, 32'hdead_beef, 32'h1234_5678);
        set_req(1, FUNC_AND, 32'hffff_0000, 32'h0ff0_0ff0);
        run_job(2, 10, 1'b0);
        run_job(3, 0, 1'b0);

        // Reset asserted during WAIT
        set_req(0, FUNC_ADD, 32'd1, 32'd2);
        #1;
        check("rw_ready", 32'(req0_ready), 32'd1);
        @(negedge clk); req0_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("rw_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("rw");
        alu_fertig = 1'b1;
        alu_ergebnis = 32'd3;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check("rw_after", 32'({busy, resp1_valid, resp0_valid}), 32'd0);
        end
        alu_fertig = 1'b0;
        ptr_m = 0;

        // Randomized jobs against the reference model
        for (int j = 0; j < 24; j++) begin
            int m;
            m = $urandom_range(1, 3);
            req0_valid = 1'b0; req1_valid = 1'b0;
            if (m != 2) set_req(0, funcs[$urandom_range(0, 5)], $urandom, $urandom);
            if (m != 1) set_req(1, funcs[$urandom_range(0, 5)], $urandom, $urandom);
            run_job($urandom_range(1, 12), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
